// File: rtl/key_filter_pkg.sv
// Shared definitions for the key filter family: channel FSM encoding and a
// counter-width helper used to size the debounce and hold counters.
package key_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } kf_state_e;

  // Bits needed to hold the values 0..n-1; never less than one bit.
  function automatic int kf_width(input int n);
    int w;
    w = 1;
    while ((32'd1 << w) < 32'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: input synchroniser, debounce/hold FSM and registered
// press, release, long-press and auto-repeat flags.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int REPEAT_EN       = 1,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Key,
  output logic Key_State,
  output logic Key_P_Flag,
  output logic Key_R_Flag,
  output logic Key_L_Flag,
  output logic Key_Rep_Flag
);

  localparam int DW = kf_width(DEBOUNCE_CYCLES);
  localparam int HW = kf_width(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_LONG   = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_SAT    = HW'(LONG_CYCLES);
  localparam logic          REP_ON      = (REPEAT_EN != 0);
  // Reloading below the long threshold makes the next hit land one repeat period later.
  localparam logic [HW-1:0] HCNT_RELOAD = REP_ON ? HW'(LONG_CYCLES - REPEAT_CYCLES) : HCNT_SAT;

  logic            key_norm_s;
  logic [1:0]      sync_r;
  logic            lvl_s;
  logic            dbnc_done_s;
  logic            hold_hit_s;
  kf_state_e       state_r;
  kf_state_e       state_nxt_s;
  logic [DW-1:0]   dcnt_r;
  logic [DW-1:0]   dcnt_nxt_s;
  logic [HW-1:0]   hcnt_r;
  logic [HW-1:0]   hcnt_nxt_s;
  logic            long_done_r;
  logic            long_done_nxt_s;
  logic            key_state_nxt_s;
  logic            p_nxt_s;
  logic            r_nxt_s;
  logic            l_nxt_s;
  logic            rep_nxt_s;

  // Normalise before synchronising so that 1 always means released.
  assign key_norm_s  = (ACTIVE_LOW != 0) ? Key : ~Key;
  assign lvl_s       = sync_r[1];
  assign dbnc_done_s = (dcnt_r == DCNT_LAST);
  assign hold_hit_s  = (hcnt_r == HCNT_LONG);

  // Two-flop synchroniser, reset to the released level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], key_norm_s};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= ST_IDLE;
      dcnt_r       <= '0;
      hcnt_r       <= '0;
      long_done_r  <= 1'b0;
      Key_State    <= 1'b1;
      Key_P_Flag   <= 1'b0;
      Key_R_Flag   <= 1'b0;
      Key_L_Flag   <= 1'b0;
      Key_Rep_Flag <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      dcnt_r       <= dcnt_nxt_s;
      hcnt_r       <= hcnt_nxt_s;
      long_done_r  <= long_done_nxt_s;
      Key_State    <= key_state_nxt_s;
      Key_P_Flag   <= p_nxt_s;
      Key_R_Flag   <= r_nxt_s;
      Key_L_Flag   <= l_nxt_s;
      Key_Rep_Flag <= rep_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE:      state_nxt_s = lvl_s ? ST_IDLE : ST_PRESS_CHK;
      ST_PRESS_CHK: begin
        if (lvl_s) begin
          state_nxt_s = ST_IDLE;
        end else if (dbnc_done_s) begin
          state_nxt_s = ST_HELD;
        end else begin
          state_nxt_s = ST_PRESS_CHK;
        end
      end
      ST_HELD:      state_nxt_s = lvl_s ? ST_REL_CHK : ST_HELD;
      ST_REL_CHK: begin
        if (!lvl_s) begin
          state_nxt_s = ST_HELD;
        end else if (dbnc_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REL_CHK;
        end
      end
      default:      state_nxt_s = ST_IDLE;
    endcase
  end

  // Counter updates and flag generation.
  always_comb begin
    dcnt_nxt_s      = dcnt_r;
    hcnt_nxt_s      = hcnt_r;
    long_done_nxt_s = long_done_r;
    key_state_nxt_s = Key_State;
    p_nxt_s         = 1'b0;
    r_nxt_s         = 1'b0;
    l_nxt_s         = 1'b0;
    rep_nxt_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        dcnt_nxt_s = '0;
      end
      ST_PRESS_CHK: begin
        if (lvl_s) begin
          dcnt_nxt_s = '0;
        end else if (dbnc_done_s) begin
          dcnt_nxt_s      = '0;
          hcnt_nxt_s      = '0;
          long_done_nxt_s = 1'b0;
          key_state_nxt_s = 1'b0;
          p_nxt_s         = 1'b1;
        end else begin
          dcnt_nxt_s = dcnt_r + 1'b1;
        end
      end
      ST_HELD: begin
        if (lvl_s) begin
          dcnt_nxt_s = '0;
        end else if (hold_hit_s) begin
          // First hit is the long press; later hits only occur with repeat enabled.
          if (long_done_r) begin
            rep_nxt_s = REP_ON;
          end else begin
            l_nxt_s = 1'b1;
          end
          long_done_nxt_s = 1'b1;
          hcnt_nxt_s      = HCNT_RELOAD;
        end else if (hcnt_r == HCNT_SAT) begin
          hcnt_nxt_s = hcnt_r;
        end else begin
          hcnt_nxt_s = hcnt_r + 1'b1;
        end
      end
      ST_REL_CHK: begin
        if (!lvl_s) begin
          dcnt_nxt_s = '0;
        end else if (dbnc_done_s) begin
          dcnt_nxt_s      = '0;
          key_state_nxt_s = 1'b1;
          r_nxt_s         = 1'b1;
        end else begin
          dcnt_nxt_s = dcnt_r + 1'b1;
        end
      end
      default: begin
        dcnt_nxt_s = '0;
        hcnt_nxt_s = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_filter_array.sv
// N-channel key debouncer bank: independent key_filter_ch instances plus the
// combined press/release flag per channel.
module key_filter_array
  import key_filter_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int REPEAT_EN       = 1,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [N_KEYS-1:0] Key,
  output logic [N_KEYS-1:0] Key_State,
  output logic [N_KEYS-1:0] Key_P_Flag,
  output logic [N_KEYS-1:0] Key_R_Flag,
  output logic [N_KEYS-1:0] Key_L_Flag,
  output logic [N_KEYS-1:0] Key_Rep_Flag,
  output logic [N_KEYS-1:0] Key_Flag
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_filter_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Key          (Key[g]),
      .Key_State    (Key_State[g]),
      .Key_P_Flag   (Key_P_Flag[g]),
      .Key_R_Flag   (Key_R_Flag[g]),
      .Key_L_Flag   (Key_L_Flag[g]),
      .Key_Rep_Flag (Key_Rep_Flag[g])
    );
  end

  // Both inputs are registered, so this stays aligned with the individual flags.
  assign Key_Flag = Key_P_Flag | Key_R_Flag;

endmodule
